// File: rtl/gf_sram_bank_arbiter.sv
// Two-port round-robin front end for the 2048x32 GF single-port SRAM macro,
// with optional post-reset zero fill of every word.
module gf_sram_bank_arbiter #(
    parameter int unsigned NUM_WORDS     = 2048,
    parameter int unsigned ADDR_WIDTH    = 11,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  init_done_o,

    input  logic                  p0_req_i,
    output logic                  p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic                  p0_we_i,
    input  logic [3:0]            p0_be_i,
    input  logic [31:0]           p0_wdata_i,
    output logic                  p0_rvalid_o,
    output logic [31:0]           p0_rdata_o,

    input  logic                  p1_req_i,
    output logic                  p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic                  p1_we_i,
    input  logic [3:0]            p1_be_i,
    input  logic [31:0]           p1_wdata_i,
    output logic                  p1_rvalid_o,
    output logic [31:0]           p1_rdata_o,

    output logic                  mem_cen_o,
    output logic                  mem_rdwen_o,
    output logic [1:0]            mem_as_o,
    output logic [6:0]            mem_aw_o,
    output logic [1:0]            mem_ac_o,
    output logic [31:0]           mem_d_o,
    output logic [31:0]           mem_bw_o,
    input  logic [31:0]           mem_q_i,

    output logic [15:0]           conflict_cnt_o
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rr_q, rr_d;
    logic                  rv_q, rv_d;
    logic                  rid_q, rid_d;
    logic [15:0]           cf_q, cf_d;

    logic                  run;
    logic                  gnt0, gnt1, gnt_any;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [3:0]            sel_be;
    logic [31:0]           sel_wdata;
    logic [31:0]           be_mask;
    logic [ADDR_WIDTH-1:0] mem_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            rv_q    <= 1'b0;
            rid_q   <= 1'b0;
            cf_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
            cf_q    <= cf_d;
        end
    end

    // The fill counter parks on the last word; it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_WAIT: state_d = INIT_ON_RESET ? ST_INIT : ST_RUN;
            ST_INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_WAIT;
        endcase
    end

    assign run     = (state_q == ST_RUN);
    assign gnt0    = run & p0_req_i & (~p1_req_i | ~rr_q);
    assign gnt1    = run & p1_req_i & (~p0_req_i | rr_q);
    assign gnt_any = gnt0 | gnt1;

    assign p0_gnt_o    = gnt0;
    assign p1_gnt_o    = gnt1;
    assign init_done_o = run;

    assign sel_addr  = gnt1 ? p1_addr_i  : p0_addr_i;
    assign sel_we    = gnt1 ? p1_we_i    : p0_we_i;
    assign sel_be    = gnt1 ? p1_be_i    : p0_be_i;
    assign sel_wdata = gnt1 ? p1_wdata_i : p0_wdata_i;

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < 4; i++) begin
            be_mask[8*i +: 8] = {8{sel_be[i]}};
        end
    end

    always_comb begin
        mem_cen_o   = 1'b1;
        mem_rdwen_o = 1'b0;
        mem_addr    = '0;
        mem_d_o     = '0;
        mem_bw_o    = '0;
        unique case (state_q)
            ST_WAIT: mem_rdwen_o = 1'b1;
            ST_INIT: begin
                mem_cen_o = 1'b0;
                mem_addr  = cnt_q;
                mem_bw_o  = '1;
            end
            ST_RUN: begin
                if (gnt_any) begin
                    mem_cen_o   = 1'b0;
                    mem_rdwen_o = ~sel_we;
                    mem_addr    = sel_addr;
                    mem_d_o     = sel_wdata;
                    mem_bw_o    = sel_we ? be_mask : 32'h0;
                end
            end
            default: mem_rdwen_o = 1'b1;
        endcase
    end

    assign mem_ac_o = mem_addr[1:0];
    assign mem_aw_o = mem_addr[8:2];
    assign mem_as_o = mem_addr[10:9];

    always_comb begin
        rr_d  = rr_q;
        rv_d  = gnt_any & ~sel_we;
        rid_d = rid_q;
        cf_d  = cf_q;
        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end
        if (gnt_any & ~sel_we) begin
            rid_d = gnt1;
        end
        if (run & p0_req_i & p1_req_i & (cf_q != 16'hFFFF)) begin
            cf_d = cf_q + 16'd1;
        end
    end

    // Macro Q is only meaningful the cycle after a read; steer it to the owner.
    assign p0_rvalid_o = rv_q & ~rid_q;
    assign p1_rvalid_o = rv_q & rid_q;
    assign p0_rdata_o  = p0_rvalid_o ? mem_q_i : 32'h0;
    assign p1_rdata_o  = p1_rvalid_o ? mem_q_i : 32'h0;

    assign conflict_cnt_o = cf_q;

endmodule

// File: tb/tb_gf_sram_bank_arbiter.sv
// Bench for gf_sram_bank_arbiter: SRAM macro model, reference memory model,
// per-cycle compare plus directed literal checks.
module tb_gf_sram_bank_arbiter;

    localparam int NW = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        p0_req, p0_we, p1_req, p1_we;
    logic [10:0] p0_addr, p1_addr;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] p0_wdata, p1_wdata;

    logic        init_done_o, p0_gnt_o, p1_gnt_o;
    logic        p0_rvalid_o, p1_rvalid_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        mem_cen_o, mem_rdwen_o;
    logic [1:0]  mem_as_o, mem_ac_o;
    logic [6:0]  mem_aw_o;
    logic [31:0] mem_d_o, mem_bw_o, mem_q;
    logic [15:0] conflict_cnt_o;

    logic        d0_done, d0_gnt0, d0_gnt1, d0_rv0, d0_rv1;
    logic [31:0] d0_rd0, d0_rd1, d0_d, d0_bw;
    logic        d0_cen, d0_rdwen;
    logic [1:0]  d0_as, d0_ac;
    logic [6:0]  d0_aw;
    logic [15:0] d0_cnt;

    gf_sram_bank_arbiter #(.NUM_WORDS(2048), .ADDR_WIDTH(11), .INIT_ON_RESET(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .init_done_o(init_done_o),
        .p0_req_i(p0_req), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr),
        .p0_we_i(p0_we), .p0_be_i(p0_be), .p0_wdata_i(p0_wdata),
        .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr),
        .p1_we_i(p1_we), .p1_be_i(p1_be), .p1_wdata_i(p1_wdata),
        .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .mem_cen_o(mem_cen_o), .mem_rdwen_o(mem_rdwen_o),
        .mem_as_o(mem_as_o), .mem_aw_o(mem_aw_o), .mem_ac_o(mem_ac_o),
        .mem_d_o(mem_d_o), .mem_bw_o(mem_bw_o), .mem_q_i(mem_q),
        .conflict_cnt_o(conflict_cnt_o)
    );

    gf_sram_bank_arbiter #(.NUM_WORDS(2048), .ADDR_WIDTH(11), .INIT_ON_RESET(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .init_done_o(d0_done),
        .p0_req_i(1'b0), .p0_gnt_o(d0_gnt0), .p0_addr_i(11'h000),
        .p0_we_i(1'b0), .p0_be_i(4'h0), .p0_wdata_i(32'h0),
        .p0_rvalid_o(d0_rv0), .p0_rdata_o(d0_rd0),
        .p1_req_i(1'b1), .p1_gnt_o(d0_gnt1), .p1_addr_i(11'h3C3),
        .p1_we_i(1'b0), .p1_be_i(4'hF), .p1_wdata_i(32'hFFFF_0000),
        .p1_rvalid_o(d0_rv1), .p1_rdata_o(d0_rd1),
        .mem_cen_o(d0_cen), .mem_rdwen_o(d0_rdwen),
        .mem_as_o(d0_as), .mem_aw_o(d0_aw), .mem_ac_o(d0_ac),
        .mem_d_o(d0_d), .mem_bw_o(d0_bw), .mem_q_i(32'h1234_5678),
        .conflict_cnt_o(d0_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Macro model: registered Q, active-high per-bit write mask.
    logic [10:0] maddr;
    logic [31:0] sram [NW];
    assign maddr = {mem_as_o, mem_aw_o, mem_ac_o};

    initial begin
        for (int i = 0; i < NW; i++) sram[i] = 32'hA5A5_0000 | i;
        mem_q = 32'h0;
    end

    always @(posedge clk) begin
        if (!mem_cen_o) begin
            if (!mem_rdwen_o) sram[maddr] <= (sram[maddr] & ~mem_bw_o) | (mem_d_o & mem_bw_o);
            else              mem_q <= sram[maddr];
        end
    end

    // Reference model: phase from cycles since reset release, word-level memory.
    int          m_cyc;
    logic        m_rr, m_rv, m_rport;
    logic [31:0] m_rdata;
    logic [15:0] m_cnt;
    bit   [31:0] ref_mem [NW];

    function automatic logic [1:0] exp_gnt();
        if (!rst_n || m_cyc <= NW) return 2'b00;
        return {p1_req & (!p0_req | m_rr), p0_req & (!p1_req | !m_rr)};
    endfunction

    function automatic logic [31:0] mask_of(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        if (be[0]) m = m | 32'h0000_00FF;
        if (be[1]) m = m | 32'h0000_FF00;
        if (be[2]) m = m | 32'h00FF_0000;
        if (be[3]) m = m | 32'hFF00_0000;
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc   <= 0;
            m_rr    <= 1'b0;
            m_rv    <= 1'b0;
            m_rport <= 1'b0;
            m_rdata <= 32'h0;
            m_cnt   <= 16'h0;
        end else begin
            logic [1:0] g;
            g = exp_gnt();
            m_rv <= 1'b0;
            if (m_cyc >= 1 && m_cyc <= NW) ref_mem[m_cyc-1] <= 32'h0;
            if (m_cyc > NW && p0_req && p1_req && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            if (g[0]) begin
                m_rr <= 1'b1;
                if (p0_we) ref_mem[p0_addr] <= (ref_mem[p0_addr] & ~mask_of(p0_be)) | (p0_wdata & mask_of(p0_be));
                else begin m_rv <= 1'b1; m_rport <= 1'b0; m_rdata <= ref_mem[p0_addr]; end
            end
            if (g[1]) begin
                m_rr <= 1'b0;
                if (p1_we) ref_mem[p1_addr] <= (ref_mem[p1_addr] & ~mask_of(p1_be)) | (p1_wdata & mask_of(p1_be));
                else begin m_rv <= 1'b1; m_rport <= 1'b1; m_rdata <= ref_mem[p1_addr]; end
            end
            if (m_cyc < 1000000) m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        logic [1:0]  g;
        logic        wt, ini, run, r0;
        logic        e_rdwen;
        logic [10:0] e_addr;
        logic [31:0] e_d, e_bw;
        g   = exp_gnt();
        wt  = !rst_n || m_cyc == 0;
        ini = rst_n && m_cyc >= 1 && m_cyc <= NW;
        run = rst_n && m_cyc > NW;
        e_rdwen = 1'b0; e_addr = 11'h0; e_d = 32'h0; e_bw = 32'h0;
        if (wt) e_rdwen = 1'b1;
        if (ini) begin e_addr = 11'(m_cyc - 1); e_bw = 32'hFFFF_FFFF; end
        if (g[0]) begin
            e_rdwen = !p0_we; e_addr = p0_addr; e_d = p0_wdata;
            e_bw = p0_we ? mask_of(p0_be) : 32'h0;
        end
        if (g[1]) begin
            e_rdwen = !p1_we; e_addr = p1_addr; e_d = p1_wdata;
            e_bw = p1_we ? mask_of(p1_be) : 32'h0;
        end
        check("done", init_done_o, run);
        check("gnt", {p1_gnt_o, p0_gnt_o}, g);
        check("cen", mem_cen_o, !(ini || g != 0));
        check("rdwen", mem_rdwen_o, e_rdwen);
        check("addr", maddr, e_addr);
        check("d", mem_d_o, e_d);
        check("bw", mem_bw_o, e_bw);
        check("rvalid", {p1_rvalid_o, p0_rvalid_o}, {m_rv && m_rport, m_rv && !m_rport});
        check("rdata0", p0_rdata_o, (m_rv && !m_rport) ? m_rdata : 32'h0);
        check("rdata1", p1_rdata_o, (m_rv && m_rport) ? m_rdata : 32'h0);
        check("conflict", conflict_cnt_o, m_cnt);
        r0 = rst_n && m_cyc >= 1;
        check("d0_done_gnt", {d0_done, d0_gnt1, d0_gnt0}, {r0, r0, 1'b0});
        check("d0_mem", {d0_cen, d0_rdwen, d0_as, d0_aw, d0_ac},
              r0 ? {1'b0, 1'b1, 2'd1, 7'h70, 2'd3} : {1'b1, 1'b1, 11'h0});
        check("d0_d_bw", {d0_d ^ d0_bw}, r0 ? 32'hFFFF_0000 : 32'h0);
        check("d0_rv", {d0_rv1, d0_rv0}, {rst_n && m_cyc >= 2, 1'b0});
        check("d0_rdata", d0_rd1 | d0_rd0, (rst_n && m_cyc >= 2) ? 32'h1234_5678 : 32'h0);
        check("d0_cnt", d0_cnt, 16'h0);
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    endtask

    // Walks WAIT + INIT with literal checks; bounded wait for init_done.
    task automatic wait_init(input string tag);
        int c;
        bit found;
        found = 0;
        for (c = 0; c < 2100; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check({tag, "_wait_cen"}, mem_cen_o, 1'b1);
                check({tag, "_wait_rv"}, p0_rvalid_o, 1'b0);
                check({tag, "_d0_wait"}, d0_done, 1'b0);
            end
            if (c == 1) begin
                check({tag, "_init0"}, {mem_cen_o, mem_rdwen_o, maddr}, {2'b00, 11'h000});
                check({tag, "_init0_bw"}, mem_bw_o, 32'hFFFF_FFFF);
                check({tag, "_d0_run"}, {d0_done, d0_gnt1}, 2'b11);
            end
            if (c == 2048) check({tag, "_initlast"}, maddr, 11'h7FF);
            if (c > 0 && c < 2049) check({tag, "_nognt"}, p0_gnt_o, 1'b0);
            if (init_done_o) begin found = 1; break; end
            next();
        end
        check({tag, "_done_cycle"}, c, found ? 32'd2049 : 32'hFFFF_FFFF);
        next();
    endtask

    initial begin
        rst_n = 0;
        idle();
        p0_addr = 0; p1_addr = 0; p0_be = 0; p1_be = 0; p0_wdata = 0; p1_wdata = 0;
        p0_req = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        wait_init("init1");

        idle();
        p0_req = 1; p0_we = 1; p0_addr = 11'h5A7; p0_be = 4'b0101; p0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("wr_gnt", p0_gnt_o, 1'b1);
        check("wr_split", {mem_as_o, mem_aw_o, mem_ac_o}, {2'd2, 7'h69, 2'd3});
        check("wr_bw", mem_bw_o, 32'h00FF_00FF);
        check("wr_rdwen", mem_rdwen_o, 1'b0);
        next();
        p0_we = 0;
        @(negedge clk);
        check("rd_gnt_rdwen", {p0_gnt_o, mem_rdwen_o}, 2'b11);
        next();
        idle();
        @(negedge clk);
        check("rd_rvalid", {p1_rvalid_o, p0_rvalid_o}, 2'b01);
        check("rd_data", p0_rdata_o, 32'h00AD_00EF);
        check("rd_other", p1_rdata_o, 32'h0);
        next();

        p1_req = 1; p1_we = 1; p1_addr = 11'h005; p1_be = 4'hF; p1_wdata = 32'h1122_3344;
        next();
        p1_we = 0; p0_req = 1; p0_addr = 11'h5A7;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("alt_gnt", {p1_gnt_o, p0_gnt_o}, (i % 2 == 0) ? 2'b01 : 2'b10);
            next();
        end
        idle();
        @(negedge clk);
        check("conflict6", conflict_cnt_o, 16'd6);
        check("alt_last_rv", {p1_rvalid_o, p1_rdata_o}, {1'b1, 32'h1122_3344});
        next();

        p0_req = 1; p1_req = 1;
        for (int i = 0; i < 65540; i++) begin
            p0_addr = 11'($urandom_range(0, 2047));
            p1_addr = 11'($urandom_range(0, 2047));
            next();
        end
        idle();
        @(negedge clk);
        check("conflict_sat", conflict_cnt_o, 16'hFFFF);
        next();

        p0_req = 1; p0_addr = 11'h005;
        next();
        idle();
        #1 rst_n = 0;
        @(negedge clk);
        check("rst_rv", {p1_rvalid_o, p0_rvalid_o}, 2'b00);
        check("rst_mem", {mem_cen_o, mem_rdwen_o, conflict_cnt_o}, {2'b11, 16'h0});
        next();
        rst_n = 1;
        wait_init("init2");

        idle();
        p1_req = 1; p1_addr = 11'h5A7;
        next();
        idle();
        @(negedge clk);
        check("post_init_rd", {p1_rvalid_o, p1_rdata_o}, {1'b1, 32'h0});
        next();
        repeat (2) next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
